threshold_stage: RTL

- Downstream neighbour of the image reader. Consumes its even/odd RGB pixel-pair stream, qualified by horizontal_Pulse and framed by vertical_Pulse.
- Per pixel: sums R+G+B and compares the sum against 3*THRESHOLD. Emits a binarised pair: each pixel is 255 on all channels or 0 on all channels.
- Output pairs are tagged with row and pair-column coordinates. A frame-done flag is produced for the downstream writer stage.

---
 rtl/threshold_stage.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/threshold_stage.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | threshold_stage: 2-stage binariser for even/odd RGB pixel pairs.          |
// | frame_Done rises in the same cycle valid_Out presents the frame's last    |
// | pair.                                                  Revision: 1.0      |
// +---------------------------------------------------------------------------+
module threshold_stage #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int THRESHOLD    = 90
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_R_Even,
  input  logic [7:0] data_G_Even,
  input  logic [7:0] data_B_Even,
  input  logic [7:0] data_R_Odd,
  input  logic [7:0] data_G_Odd,
  input  logic [7:0] data_B_Odd,
  input  logic       horizontal_Pulse,
  input  logic       vertical_Pulse,
  output logic [7:0] out_R_Even,
  output logic [7:0] out_G_Even,
  output logic [7:0] out_B_Even,
  output logic [7:0] out_R_Odd,
  output logic [7:0] out_G_Odd,
  output logic [7:0] out_B_Odd,
  output logic       valid_Out,
  output logic [9:0] pixel_Column,
  output logic [8:0] pixel_Row,
  output logic       frame_Done
);

  localparam logic [9:0] C_LAST_COL = 10'(IMAGE_WIDTH / 2 - 1);
  localparam logic [8:0] C_LAST_ROW = 9'(IMAGE_HEIGHT - 1);
  localparam logic [9:0] C_CMP      = 10'(3 * THRESHOLD);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [8:0] row_q, row_d;

  logic       s1_valid_q, s1_valid_d;
  logic       s1_last_q, s1_last_d;
  logic [9:0] sum_even_q, sum_even_d;
  logic [9:0] sum_odd_q, sum_odd_d;
  logic [9:0] s1_col_q, s1_col_d;
  logic [8:0] s1_row_q, s1_row_d;

  logic       valid_q, valid_d;
  logic [7:0] out_even_q, out_even_d;
  logic [7:0] out_odd_q, out_odd_d;
  logic [9:0] out_col_q, out_col_d;
  logic [8:0] out_row_q, out_row_d;
  logic       frame_done_q, frame_done_d;

  logic       w_accept;
  logic       w_is_last;
  logic [9:0] w_cur_col;
  logic [8:0] w_cur_row;

  // A frame-start pulse zeroes the coordinates seen by a coincident pair.
  assign w_cur_col = vertical_Pulse ? 10'd0 : col_q;
  assign w_cur_row = vertical_Pulse ? 9'd0 : row_q;
  assign w_accept  = horizontal_Pulse && (vertical_Pulse || (state_q == ACTIVE));
  assign w_is_last = (w_cur_col == C_LAST_COL) && (w_cur_row == C_LAST_ROW);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    s1_valid_d   = 1'b0;
    s1_last_d    = 1'b0;
    sum_even_d   = sum_even_q;
    sum_odd_d    = sum_odd_q;
    s1_col_d     = s1_col_q;
    s1_row_d     = s1_row_q;
    valid_d      = 1'b0;
    out_even_d   = out_even_q;
    out_odd_d    = out_odd_q;
    out_col_d    = out_col_q;
    out_row_d    = out_row_q;
    frame_done_d = frame_done_q;

    if (state_q == DRAIN && s1_last_q) begin
      state_d = IDLE;
    end
    if (s1_last_q) begin
      frame_done_d = 1'b1;
    end

    // Frame start overrides both the drain exit and a pending frame_Done.
    if (vertical_Pulse) begin
      state_d      = ACTIVE;
      col_d        = 10'd0;
      row_d        = 9'd0;
      frame_done_d = 1'b0;
    end

    if (w_accept) begin
      s1_valid_d = 1'b1;
      sum_even_d = {2'b00, data_R_Even} + {2'b00, data_G_Even} + {2'b00, data_B_Even};
      sum_odd_d  = {2'b00, data_R_Odd} + {2'b00, data_G_Odd} + {2'b00, data_B_Odd};
      s1_col_d   = w_cur_col;
      s1_row_d   = w_cur_row;
      if (w_is_last) begin
        s1_last_d = 1'b1;
        col_d     = 10'd0;
        row_d     = 9'd0;
        state_d   = DRAIN;
      end else if (w_cur_col == C_LAST_COL) begin
        col_d = 10'd0;
        row_d = w_cur_row + 9'd1;
      end else begin
        col_d = w_cur_col + 10'd1;
        row_d = w_cur_row;
      end
    end

    if (s1_valid_q) begin
      valid_d    = 1'b1;
      out_even_d = (sum_even_q > C_CMP) ? 8'd255 : 8'd0;
      out_odd_d  = (sum_odd_q > C_CMP) ? 8'd255 : 8'd0;
      out_col_d  = s1_col_q;
      out_row_d  = s1_row_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= 10'd0;
      row_q        <= 9'd0;
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      sum_even_q   <= 10'd0;
      sum_odd_q    <= 10'd0;
      s1_col_q     <= 10'd0;
      s1_row_q     <= 9'd0;
      valid_q      <= 1'b0;
      out_even_q   <= 8'd0;
      out_odd_q    <= 8'd0;
      out_col_q    <= 10'd0;
      out_row_q    <= 9'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      sum_even_q   <= sum_even_d;
      sum_odd_q    <= sum_odd_d;
      s1_col_q     <= s1_col_d;
      s1_row_q     <= s1_row_d;
      valid_q      <= valid_d;
      out_even_q   <= out_even_d;
      out_odd_q    <= out_odd_d;
      out_col_q    <= out_col_d;
      out_row_q    <= out_row_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_R_Even   = out_even_q;
  assign out_G_Even   = out_even_q;
  assign out_B_Even   = out_even_q;
  assign out_R_Odd    = out_odd_q;
  assign out_G_Odd    = out_odd_q;
  assign out_B_Odd    = out_odd_q;
  assign valid_Out    = valid_q;
  assign pixel_Column = out_col_q;
  assign pixel_Row    = out_row_q;
  assign frame_Done   = frame_done_q;

endmodule
`default_nettype wire
